// File: rtl/onehot_req_arbiter_4_pkg.sv
// Shared constants, FSM encoding and channel-selection helpers for the
// 4-channel one-hot request arbiter.
package onehot_req_arbiter_4_pkg;

  localparam int NUM_CH = 4;
  localparam int PTR_W  = 2;

  typedef logic [NUM_CH-1:0] ch_vec_t;
  typedef logic [PTR_W-1:0]  ch_idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Fixed priority: bit 0 wins; the downward scan leaves the lowest set bit.
  function automatic ch_vec_t pick_fixed(input ch_vec_t p);
    ch_vec_t r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (p[k]) begin
        r    = '0;
        r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic ch_vec_t pick_rr(input ch_vec_t p, input ch_idx_t ptr);
    ch_vec_t r;
    ch_idx_t idx;
    logic    found;
    r     = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = ptr + ch_idx_t'(off);
      if (!found && p[idx]) begin
        r[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic ch_idx_t onehot_idx(input ch_vec_t v);
    ch_idx_t idx;
    idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (v[k]) idx = ch_idx_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_req_arbiter_4_req_sync.sv
// One-bit SYNC_STAGES-deep synchroniser followed by a rising-edge detector.
// rise is high for one cycle when the synchronised level goes 0 -> 1.
module onehot_req_arbiter_4_req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/onehot_req_arbiter_4.sv
// Sticky-pending request arbiter issuing one registered one-hot grant at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module onehot_req_arbiter_4
  import onehot_req_arbiter_4_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [3:0] I,
  output logic       busy,
  output logic [3:0] pending
);

  // Handshake: a grant is presented on I while busy=1 and held stable until the
  // consumer samples ack=1 in the same cycle; ack outside a grant has no effect.

  ch_vec_t    rise;
  ch_vec_t    pending_q, pending_d;
  ch_vec_t    grant_q, grant_d;
  ch_vec_t    sel;
  arb_state_e state_q, state_d;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_sync
    onehot_req_arbiter_4_req_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .req_async(req[k]),
      .rise     (rise[k])
    );
  end

`ifdef ARB_ROUND_ROBIN_EN
  ch_idx_t ptr_q, ptr_d;

  assign sel = pick_rr(pending_q, ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && pending_q != '0) ptr_d = onehot_idx(sel);
  end

  // Pointer resets to the last channel so the first search begins at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= ch_idx_t'(NUM_CH - 1);
    else     ptr_q <= ptr_d;
  end
`else
  assign sel = pick_fixed(pending_q);
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pending_d = pending_q | rise;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          grant_d = sel;
          state_d = ST_GRANT;
        end else begin
          grant_d = '0;
        end
      end
      ST_GRANT: begin
        // A fresh edge on the granted channel survives the clear.
        if (ack) begin
          pending_d = (pending_q & ~grant_q) | rise;
          grant_d   = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
    end
  end

  assign I       = grant_q;
  assign busy    = (state_q == ST_GRANT);
  assign pending = pending_q;

endmodule

// File: tb/tb_onehot_req_arbiter_4.sv
// Bench for onehot_req_arbiter_4: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model and a grant scoreboard.
module tb_onehot_req_arbiter_4;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req = 4'b0;
  logic       ack = 1'b0;
  logic [3:0] I;
  logic       busy;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;
  logic done = 1'b0;

  logic [3:0] exp_q[$];

  // behavioural model state
  logic [3:0] m_hist[$];
  logic [3:0] m_pend;
  int         m_g;
  int         m_last;

  always #5 clk = ~clk;

  onehot_req_arbiter_4 #(
    .SYNC_STAGES(S)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .ack    (ack),
    .I      (I),
    .busy   (busy),
    .pending(pending)
  );

  function automatic logic [3:0] oh(input int k);
    logic [3:0] v;
    v = 4'b0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  function automatic int enc_y(input logic [3:0] v);
    int y;
    y = 0;
    for (int k = 0; k < 4; k++) if (v[k]) y = k;
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i <= S; i++) m_hist.push_back(4'b0);
    m_pend = 4'b0;
    m_g    = -1;
    m_last = 3;
    exp_q.delete();
  endtask

  // One clock edge of the model: req history gives the synchronised edge,
  // the pending set and the current grant follow the arbitration rules.
  task automatic model_edge();
    logic [3:0] rise;
    logic [3:0] old;
    int         pick;
    rise = m_hist[S-1] & ~m_hist[S];
    old  = m_pend;
    if (m_g >= 0) begin
      if (ack) begin
        m_pend[m_g] = 1'b0;
        m_g = -1;
      end
    end else if (old != 4'b0) begin
      pick = -1;
`ifdef ARB_ROUND_ROBIN_EN
      for (int off = 1; off <= 4; off++)
        if (pick < 0 && old[(m_last + off) % 4]) pick = (m_last + off) % 4;
      m_last = pick;
`else
      for (int k = 0; k < 4; k++)
        if (pick < 0 && old[k]) pick = k;
`endif
      m_g = pick;
      exp_q.push_back(oh(pick));
    end
    m_pend = m_pend | rise;
    m_hist.push_front(req);
    void'(m_hist.pop_back());
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] mask);
    req = mask;
    step();
    req = 4'b0;
  endtask

  task automatic wait_grant(input int budget);
    for (int i = 0; i < budget && m_g < 0; i++) step();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic drain(input int n);
    ack = 1'b1;
    repeat (n) step();
    ack = 1'b0;
  endtask

  // monitor: per-cycle model comparison plus scoreboard pop on each new grant
  initial begin
    logic [3:0] prev_i;
    logic [3:0] e;
    logic       final_done;
    prev_i     = 4'b0;
    final_done = 1'b0;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (rst) check("rst_I", {28'b0, I}, 32'd0);
      check("onehot0", {31'b0, $onehot0(I)}, 32'd1);
      check("I_model", {28'b0, I}, {28'b0, oh(m_g)});
      check("busy", {31'b0, busy}, {31'b0, (m_g >= 0)});
      check("pending", {28'b0, pending}, {28'b0, m_pend});
      if (I != 4'b0 && prev_i == 4'b0) begin
        if (exp_q.size() == 0) begin
          check("grant_unexpected", {28'b0, I}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("grant", {28'b0, I}, {28'b0, e});
          check("enc_y", enc_y(I), enc_y(e));
        end
      end
      prev_i = I;
      if (done && !final_done) begin
        check("leftover_grants", exp_q.size(), 32'd0);
        final_done = 1'b1;
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;

    // reset held with all requests high, then first grant after release
    req = 4'b1111;
    repeat (4) step();
    rst = 1'b0;
    wait_grant(20);
    ack_pulse();
    req = 4'b0;
    drain(16);
    repeat (3) step();

    // single request, held grant, then ack
    pulse(4'b0100);
    wait_grant(20);
    repeat (3) step();
    ack_pulse();
    repeat (2) step();

    // three-way contention
    pulse(4'b1011);
    repeat (3) begin
      wait_grant(20);
      step();
      ack_pulse();
    end
    repeat (2) step();

    // selection order after ch0 was last granted
    pulse(4'b0001);
    wait_grant(20);
    ack_pulse();
    pulse(4'b0101);
    repeat (2) begin
      wait_grant(20);
      ack_pulse();
    end
    repeat (2) step();

    // re-armed edge on ch1 lands with its ack
    pulse(4'b0010);
    wait_grant(20);
    repeat (2) step();
    req = 4'b0010;
    repeat (S) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 4'b0;
    wait_grant(20);
    step();
    ack_pulse();
    repeat (2) step();

    // asynchronous reset in the middle of a grant
    pulse(4'b1000);
    wait_grant(20);
    step();
    #2;
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
    repeat (10) step();

    // random traffic
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) req = req ^ 4'($urandom_range(0, 15));
      ack = ($urandom_range(0, 3) == 0);
      step();
    end
    req = 4'b0;
    drain(40);
    repeat (3) step();

    done = 1'b1;
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
